msi_bus_arbiter: RTL and testbench
==================================

MSI_BUS_ARBITER -- requirements
Module: msi_bus_arbiter

Interface
REQ-001 Params: ADDR_W 9, 9-bit memory address {tag[3:0], index[4:0]}; DATA_W 32, cache line data width.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 req  in  2  per-core bus transaction request; bit k = core k; held high until resp_valid[k].
REQ-005 cmd0, cmd1  in  2 each  core bus command: 00 INVALIDATE, 01 WRITE_MISS, 10 READ_MISS, 11 none.
REQ-006 addr0, addr1  in  9 each  address of the requested line.
REQ-007 snoop_abort0, snoop_abort1  in  1 each  core k holds the snooped line and supplies it.
REQ-008 snoop_data0, snoop_data1  in  32 each  line data from core k.
REQ-009 wb_req  in  2  per-core write-back request; held until wb_ack[k].
REQ-010 wb_addr0, wb_addr1 / wb_data0, wb_data1  in  9 / 32  write-back address and data.
REQ-011 mem_rdata  in  32; mem_rvalid  in  1  memory read return.
REQ-012 gnt  out  2  one-hot grant, held from SNOOP through RESP.
REQ-013 bus_valid  out 1; bus_cmd  out 2; bus_addr  out 9  snoop broadcast to the non-granted core.
REQ-014 mem_rd  out 1; mem_we  out 1; mem_addr  out 9; mem_wdata  out 32  memory port.
REQ-015 resp_valid  out 2; resp_data  out 32; resp_from_cache  out 1  completion to requester.
REQ-016 wb_ack  out 2  one-cycle write-back acknowledge.

Function
REQ-017 FSM states IDLE, WB, SNOOP, MEMRD, RESP; registered outputs except bus_*/mem_* decoded from state and latched fields.
REQ-018 IDLE: any wb_req -> WB (core0 wins if both); else any req -> SNOOP with grantee chosen by round-robin pointer rr (rr=k means core k has priority); else stay.
REQ-019 On leaving IDLE for SNOOP, latch grantee's cmd, addr; gnt asserted from the SNOOP cycle.
REQ-020 WB (1 cycle): mem_we=1, mem_addr/mem_wdata from selected core, wb_ack[k]=1 same cycle; -> IDLE.
REQ-021 SNOOP (1 cycle): bus_valid=1, bus_cmd/bus_addr = latched values; snoop_abort sampled only from the non-granted core.
REQ-022 SNOOP transitions: cmd INVALIDATE -> RESP, resp_data=0; abort=1 and cmd READ_MISS/WRITE_MISS -> RESP, resp_data=snoop data, resp_from_cache=1; otherwise -> MEMRD.
REQ-023 cmd 11 at grant: treated as no-op, straight to RESP with resp_data=0.
REQ-024 MEMRD: mem_rd=1, mem_addr=latched addr, held until mem_rvalid; capture mem_rdata, resp_from_cache=0; -> RESP.
REQ-025 mem_rvalid outside MEMRD ignored.
REQ-026 RESP (1 cycle): resp_valid[grantee]=1, resp_data stable; rr <= ~grantee; gnt deasserts next cycle; -> IDLE.
REQ-027 Minimum latency req->resp_valid: 2 cycles after IDLE sample (cache hit-in-peer or invalidate); memory path 3 + memory wait.
REQ-028 Write-backs preempt only in IDLE; never abort an in-flight transaction.
REQ-029 req dropped mid-transaction: transaction completes; resp_valid still pulsed.
REQ-030 At most one of mem_rd, mem_we high in any cycle.

Reset
REQ-031 rst_n low, at any time including mid-transaction: state IDLE, rr=0, all outputs 0, latched cmd/addr/data 0.
REQ-032 First rising clk edge after rst_n deassert may start a transaction.

Verification
REQ-033 Reset, req=01, cmd0=10, addr0=0x025, no abort, mem_rvalid 2 cycles later with 0xDEADBEEF -> bus_valid once with addr 0x025, mem_rd 2 cycles, resp_valid=01, resp_data=0xDEADBEEF, resp_from_cache=0.
REQ-034 req=10, cmd1=01, addr1=0x1F3, snoop_abort0=1, snoop_data0=0x12345678 -> no mem_rd, resp_valid=10 two cycles after IDLE, resp_data=0x12345678, resp_from_cache=1.
REQ-035 req=11 held, both READ_MISS, immediate mem_rvalid -> core0 served first, then core1; a third back-to-back round serves core0 again.
REQ-036 wb_req=01 and req=10 same cycle, wb_addr0=0x040, wb_data0=0xA5A5A5A5 -> mem_we one cycle with those values, wb_ack=01, then core1 transaction.
REQ-037 cmd0=00 INVALIDATE -> bus_valid with cmd 00, resp_valid=01, resp_data=0, no memory access.
REQ-038 rst_n pulsed low during MEMRD -> all outputs 0 immediately, no resp_valid, later mem_rvalid ignored.

Source files
------------

// File: rtl/msi_bus_arbiter_if.sv
// Bus bundle between the MSI snooping arbiter (master side) and the two cores plus memory (slave side).
interface msi_bus_arbiter_if #(
    parameter int unsigned ADDR_W = 9,
    parameter int unsigned DATA_W = 32
);
    logic [1:0]        req;
    logic [1:0]        cmd0;
    logic [1:0]        cmd1;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic              snoop_abort0;
    logic              snoop_abort1;
    logic [DATA_W-1:0] snoop_data0;
    logic [DATA_W-1:0] snoop_data1;
    logic [1:0]        wb_req;
    logic [ADDR_W-1:0] wb_addr0;
    logic [ADDR_W-1:0] wb_addr1;
    logic [DATA_W-1:0] wb_data0;
    logic [DATA_W-1:0] wb_data1;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_rvalid;

    logic [1:0]        gnt;
    logic              bus_valid;
    logic [1:0]        bus_cmd;
    logic [ADDR_W-1:0] bus_addr;
    logic              mem_rd;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [1:0]        resp_valid;
    logic [DATA_W-1:0] resp_data;
    logic              resp_from_cache;
    logic [1:0]        wb_ack;

    modport master (
        input  req, cmd0, cmd1, addr0, addr1, snoop_abort0, snoop_abort1,
               snoop_data0, snoop_data1, wb_req, wb_addr0, wb_addr1,
               wb_data0, wb_data1, mem_rdata, mem_rvalid,
        output gnt, bus_valid, bus_cmd, bus_addr, mem_rd, mem_we, mem_addr,
               mem_wdata, resp_valid, resp_data, resp_from_cache, wb_ack
    );

    modport slave (
        output req, cmd0, cmd1, addr0, addr1, snoop_abort0, snoop_abort1,
               snoop_data0, snoop_data1, wb_req, wb_addr0, wb_addr1,
               wb_data0, wb_data1, mem_rdata, mem_rvalid,
        input  gnt, bus_valid, bus_cmd, bus_addr, mem_rd, mem_we, mem_addr,
               mem_wdata, resp_valid, resp_data, resp_from_cache, wb_ack
    );
endinterface

// File: rtl/msi_bus_arbiter.sv
// Two-core MSI snooping bus arbiter: round-robin grant, peer snoop, memory fallback,
// and write-backs that may only preempt while the bus is idle.
module msi_bus_arbiter #(
    parameter int unsigned ADDR_W = 9,
    parameter int unsigned DATA_W = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    msi_bus_arbiter_if.master  bus
);
    localparam logic [1:0] CMD_INV  = 2'b00;
    localparam logic [1:0] CMD_NONE = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE, ST_WB, ST_SNOOP, ST_MEMRD, ST_RESP
    } state_t;

    state_t            state, state_nxt;
    logic              rr_q, rr_nxt;
    logic              core_q, core_nxt;
    logic [1:0]        cmd_q, cmd_nxt;
    logic [ADDR_W-1:0] addr_q, addr_nxt;
    logic [DATA_W-1:0] data_q, data_nxt;
    logic [1:0]        gnt_q, gnt_nxt;
    logic [1:0]        resp_valid_q, resp_valid_nxt;
    logic [DATA_W-1:0] resp_data_q, resp_data_nxt;
    logic              from_cache_q, from_cache_nxt;
    logic [1:0]        wb_ack_q, wb_ack_nxt;

    logic              req_pick, wb_pick, peer_abort;
    logic [1:0]        req_cmd;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] peer_data;

    // Round-robin pointer only matters when both cores contend
    assign req_pick   = (bus.req == 2'b11) ? rr_q : bus.req[1];
    assign wb_pick    = ~bus.wb_req[0];
    assign req_cmd    = req_pick ? bus.cmd1  : bus.cmd0;
    assign req_addr   = req_pick ? bus.addr1 : bus.addr0;
    assign peer_abort = core_q ? bus.snoop_abort0 : bus.snoop_abort1;
    assign peer_data  = core_q ? bus.snoop_data0  : bus.snoop_data1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            rr_q         <= 1'b0;
            core_q       <= 1'b0;
            cmd_q        <= 2'b00;
            addr_q       <= '0;
            data_q       <= '0;
            gnt_q        <= 2'b00;
            resp_valid_q <= 2'b00;
            resp_data_q  <= '0;
            from_cache_q <= 1'b0;
            wb_ack_q     <= 2'b00;
        end else begin
            state        <= state_nxt;
            rr_q         <= rr_nxt;
            core_q       <= core_nxt;
            cmd_q        <= cmd_nxt;
            addr_q       <= addr_nxt;
            data_q       <= data_nxt;
            gnt_q        <= gnt_nxt;
            resp_valid_q <= resp_valid_nxt;
            resp_data_q  <= resp_data_nxt;
            from_cache_q <= from_cache_nxt;
            wb_ack_q     <= wb_ack_nxt;
        end
    end

    // Registered pulses are set on the transition into the state they accompany
    always_comb begin
        state_nxt      = state;
        rr_nxt         = rr_q;
        core_nxt       = core_q;
        cmd_nxt        = cmd_q;
        addr_nxt       = addr_q;
        data_nxt       = data_q;
        gnt_nxt        = gnt_q;
        resp_valid_nxt = 2'b00;
        resp_data_nxt  = resp_data_q;
        from_cache_nxt = from_cache_q;
        wb_ack_nxt     = 2'b00;
        case (state)
            ST_IDLE: begin
                if (|bus.wb_req) begin
                    state_nxt  = ST_WB;
                    addr_nxt   = wb_pick ? bus.wb_addr1 : bus.wb_addr0;
                    data_nxt   = wb_pick ? bus.wb_data1 : bus.wb_data0;
                    wb_ack_nxt = {wb_pick, ~wb_pick};
                end else if (|bus.req) begin
                    core_nxt = req_pick;
                    cmd_nxt  = req_cmd;
                    addr_nxt = req_addr;
                    gnt_nxt  = {req_pick, ~req_pick};
                    if (req_cmd == CMD_NONE) begin
                        state_nxt      = ST_RESP;
                        resp_valid_nxt = {req_pick, ~req_pick};
                        resp_data_nxt  = '0;
                        from_cache_nxt = 1'b0;
                    end else begin
                        state_nxt = ST_SNOOP;
                    end
                end
            end
            ST_WB: state_nxt = ST_IDLE;
            ST_SNOOP: begin
                if (cmd_q == CMD_INV || cmd_q == CMD_NONE) begin
                    state_nxt      = ST_RESP;
                    resp_valid_nxt = {core_q, ~core_q};
                    resp_data_nxt  = '0;
                    from_cache_nxt = 1'b0;
                end else if (peer_abort) begin
                    state_nxt      = ST_RESP;
                    resp_valid_nxt = {core_q, ~core_q};
                    resp_data_nxt  = peer_data;
                    from_cache_nxt = 1'b1;
                end else begin
                    state_nxt = ST_MEMRD;
                end
            end
            ST_MEMRD: begin
                if (bus.mem_rvalid) begin
                    state_nxt      = ST_RESP;
                    resp_valid_nxt = {core_q, ~core_q};
                    resp_data_nxt  = bus.mem_rdata;
                    from_cache_nxt = 1'b0;
                end
            end
            ST_RESP: begin
                state_nxt = ST_IDLE;
                rr_nxt    = ~core_q;
                gnt_nxt   = 2'b00;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign bus.gnt             = gnt_q;
    assign bus.resp_valid      = resp_valid_q;
    assign bus.resp_data       = resp_data_q;
    assign bus.resp_from_cache = from_cache_q;
    assign bus.wb_ack          = wb_ack_q;

    // Bus and memory strobes decode straight from state so they track it cycle-exactly
    assign bus.bus_valid = (state == ST_SNOOP);
    assign bus.bus_cmd   = (state == ST_SNOOP) ? cmd_q  : 2'b00;
    assign bus.bus_addr  = (state == ST_SNOOP) ? addr_q : '0;
    assign bus.mem_rd    = (state == ST_MEMRD);
    assign bus.mem_we    = (state == ST_WB);
    assign bus.mem_addr  = (state == ST_WB || state == ST_MEMRD) ? addr_q : '0;
    assign bus.mem_wdata = (state == ST_WB) ? data_q : '0;
endmodule

// File: tb/tb_msi_bus_arbiter.sv
// Directed bench for msi_bus_arbiter: linear step sequence with immediate assertions.
module tb_msi_bus_arbiter;
    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   n_bv = 0, n_rd = 0, n_we = 0, n_rv = 0, n_both = 0;
    int   snap_bv, snap_rd, snap_we, snap_rv;

    msi_bus_arbiter_if #(.ADDR_W(9), .DATA_W(32)) bus ();

    msi_bus_arbiter #(.ADDR_W(9), .DATA_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Pre-edge sampling of strobes for pulse counting
    always @(posedge clk) begin
        if (bus.bus_valid)             n_bv   <= n_bv + 1;
        if (bus.mem_rd)                n_rd   <= n_rd + 1;
        if (bus.mem_we)                n_we   <= n_we + 1;
        if (|bus.resp_valid)           n_rv   <= n_rv + 1;
        if (bus.mem_rd && bus.mem_we)  n_both <= n_both + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic snap();
        snap_bv = n_bv; snap_rd = n_rd; snap_we = n_we; snap_rv = n_rv;
    endtask

    initial begin
        rst_n = 1'b0;
        bus.req = 2'b00; bus.cmd0 = 2'b11; bus.cmd1 = 2'b11;
        bus.addr0 = '0; bus.addr1 = '0;
        bus.snoop_abort0 = 1'b0; bus.snoop_abort1 = 1'b0;
        bus.snoop_data0 = '0; bus.snoop_data1 = '0;
        bus.wb_req = 2'b00; bus.wb_addr0 = '0; bus.wb_addr1 = '0;
        bus.wb_data0 = '0; bus.wb_data1 = '0;
        bus.mem_rdata = '0; bus.mem_rvalid = 1'b0;
        step(); step();
        check("reset_ctrl", 64'({bus.gnt, bus.resp_valid, bus.wb_ack, bus.bus_valid,
                                 bus.mem_rd, bus.mem_we, bus.resp_from_cache}), 64'h0);
        check("reset_data", 64'({bus.resp_data, bus.mem_addr, bus.bus_addr}), 64'h0);

        // Read miss served from memory; request presented on the first edge after reset release
        rst_n = 1'b1;
        bus.req = 2'b01; bus.cmd0 = 2'b10; bus.addr0 = 9'h025;
        snap();
        step();
        check("t1_snoop", 64'({bus.gnt, bus.bus_valid, bus.bus_cmd, bus.bus_addr, bus.mem_rd}),
              64'({2'b01, 1'b1, 2'b10, 9'h025, 1'b0}));
        step();
        check("t1_memrd", 64'({bus.mem_rd, bus.mem_addr, bus.bus_valid}), 64'({1'b1, 9'h025, 1'b0}));
        step();
        bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hDEADBEEF;
        step();
        check("t1_resp", 64'({bus.resp_valid, bus.resp_from_cache, bus.gnt, bus.mem_rd}),
              64'({2'b01, 1'b0, 2'b01, 1'b0}));
        check("t1_data", 64'(bus.resp_data), 64'h0000_0000_DEAD_BEEF);
        bus.mem_rvalid = 1'b0; bus.req = 2'b00;
        step();
        check("t1_idle", 64'({bus.resp_valid, bus.gnt}), 64'h0);
        check("t1_counts", 64'({16'(n_bv - snap_bv), 16'(n_rd - snap_rd)}), 64'({16'd1, 16'd2}));

        // Write miss supplied by peer core 0
        bus.req = 2'b10; bus.cmd1 = 2'b01; bus.addr1 = 9'h1F3;
        bus.snoop_abort0 = 1'b1; bus.snoop_data0 = 32'h12345678;
        snap();
        step();
        check("t2_snoop", 64'({bus.gnt, bus.bus_valid, bus.bus_cmd, bus.bus_addr}),
              64'({2'b10, 1'b1, 2'b01, 9'h1F3}));
        step();
        check("t2_resp", 64'({bus.resp_valid, bus.resp_from_cache, bus.resp_data}),
              64'({2'b10, 1'b1, 32'h12345678}));
        bus.req = 2'b00; bus.snoop_abort0 = 1'b0;
        step();
        check("t2_no_memrd", 64'(n_rd - snap_rd), 64'd0);

        // Both cores contend for three back-to-back rounds with immediate memory return
        bus.req = 2'b11; bus.cmd0 = 2'b10; bus.cmd1 = 2'b10;
        bus.addr0 = 9'h011; bus.addr1 = 9'h122; bus.mem_rvalid = 1'b1;
        for (int r = 0; r < 3; r++) begin
            logic [1:0] g;
            g = (r == 1) ? 2'b10 : 2'b01;
            bus.mem_rdata = 32'hC0C0_0000 + 32'(r);
            step();
            check($sformatf("t3_gnt_r%0d", r), 64'({bus.gnt, bus.bus_addr}),
                  64'({g, (r == 1) ? 9'h122 : 9'h011}));
            step();
            check($sformatf("t3_memrd_r%0d", r), 64'(bus.mem_rd), 64'd1);
            step();
            check($sformatf("t3_resp_r%0d", r), 64'({bus.resp_valid, bus.resp_data}),
                  64'({g, 32'hC0C0_0000 + 32'(r)}));
            if (r == 2) begin
                bus.req = 2'b00; bus.mem_rvalid = 1'b0;
            end
            step();
            check($sformatf("t3_idle_r%0d", r), 64'(bus.resp_valid), 64'd0);
        end

        // Write-back beats a same-cycle request, then core 1 is served
        bus.wb_req = 2'b01; bus.wb_addr0 = 9'h040; bus.wb_data0 = 32'hA5A5A5A5;
        bus.req = 2'b10; bus.cmd1 = 2'b10; bus.addr1 = 9'h0AA;
        step();
        check("t4_wb", 64'({bus.mem_we, bus.mem_rd, bus.wb_ack, bus.gnt, bus.mem_addr, bus.mem_wdata}),
              64'({1'b1, 1'b0, 2'b01, 2'b00, 9'h040, 32'hA5A5A5A5}));
        bus.wb_req = 2'b00;
        step();
        check("t4_after_wb", 64'({bus.wb_ack, bus.mem_we}), 64'h0);
        step();
        check("t4_snoop", 64'({bus.gnt, bus.bus_valid, bus.bus_addr}), 64'({2'b10, 1'b1, 9'h0AA}));
        step();
        bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h0000600D;
        step();
        check("t4_resp", 64'({bus.resp_valid, bus.resp_data}), 64'({2'b10, 32'h0000600D}));
        bus.req = 2'b00; bus.mem_rvalid = 1'b0;
        step();

        // Command 11 completes as a no-op without a snoop broadcast
        bus.req = 2'b10; bus.cmd1 = 2'b11;
        snap();
        step();
        check("t5_noop", 64'({bus.resp_valid, bus.gnt, bus.bus_valid, bus.resp_data}),
              64'({2'b10, 2'b10, 1'b0, 32'h0}));
        bus.req = 2'b00;
        step();
        check("t5_no_bus", 64'({16'(n_bv - snap_bv), 16'(n_rd - snap_rd)}), 64'h0);

        // Invalidate: broadcast only, zero data, no memory traffic
        bus.req = 2'b01; bus.cmd0 = 2'b00; bus.addr0 = 9'h0F0;
        snap();
        step();
        check("t6_snoop", 64'({bus.bus_valid, bus.bus_cmd, bus.bus_addr}), 64'({1'b1, 2'b00, 9'h0F0}));
        step();
        check("t6_resp", 64'({bus.resp_valid, bus.resp_from_cache, bus.resp_data}),
              64'({2'b01, 1'b0, 32'h0}));
        bus.req = 2'b00;
        step();
        check("t6_no_mem", 64'({16'(n_rd - snap_rd), 16'(n_we - snap_we)}), 64'h0);

        // Reset asserted while in MEMRD; rr was left at 1 and must return to 0
        bus.req = 2'b01; bus.cmd0 = 2'b10; bus.addr0 = 9'h033;
        step();
        step();
        check("t7_memrd", 64'({bus.mem_rd, bus.gnt}), 64'({1'b1, 2'b01}));
        #1 rst_n = 1'b0;
        #1;
        check("t7_rst_outs", 64'({bus.gnt, bus.mem_rd, bus.mem_addr, bus.resp_valid, bus.bus_valid}), 64'h0);
        bus.req = 2'b00;
        snap();
        step();
        rst_n = 1'b1; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h00000BAD;
        step(); step();
        check("t7_ignored_rvalid", 64'({16'(n_rv - snap_rv), 16'(n_rd - snap_rd)}), 64'h0);

        // Contention after reset goes to core 0; core 0 drops req mid-flight yet still gets resp
        bus.req = 2'b11; bus.cmd0 = 2'b10; bus.cmd1 = 2'b10; bus.mem_rdata = 32'h0000BEEF;
        step();
        check("t8_gnt_after_rst", 64'(bus.gnt), 64'd1);
        bus.req = 2'b00;
        step();
        step();
        check("t8_resp_dropped", 64'({bus.resp_valid, bus.resp_data}), 64'({2'b01, 32'h0000BEEF}));
        bus.mem_rvalid = 1'b0;
        step();
        check("mem_exclusive", 64'(n_both), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
